// File: rtl/seq_pkg.sv
// Shared definitions for the serializer feeding the 11000 sequence detector.
// Holds the state encoding, the default word width and a constant clog2 helper.
package seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } seq_state_e;

  localparam int SEQ_W = 8;

  // Bits needed to index 0..value-1; evaluated at elaboration only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_bit_cnt.sv
// Modulo-W bit index counter with synchronous clear, enable and last-bit flag.
// The serializer uses it to track which bit of the loaded word is on xout.
module seq_bit_cnt
  import seq_pkg::*;
#(
  parameter int W = SEQ_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [clog2(W)-1:0]   cnt,
  output logic                  last
);

  localparam int CW = clog2(W);

  logic [CW-1:0] cnt_r;
  logic          last_s;

  assign last_s = (cnt_r == CW'(W - 1));

  // Bit index register; wraps to zero after the last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (last_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign last = last_s;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage driving the 11000 detector's xin, one bit per clock.
// valid/ready input, stall via shift_en, back-to-back words without a bubble.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int W          = SEQ_W,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         shift_en,
  output logic         xout,
  output logic         xout_valid,
  output logic         busy,
  output logic         word_done
);

  localparam int CW = clog2(W);

  seq_state_e    state_r, state_s;
  logic [W-1:0]  sr_r, sr_s;
  logic          xout_r, xout_s;
  logic          xv_r, xv_s;
  logic          wd_r, wd_s;
  logic          busy_r;
  logic [CW-1:0] cnt_s;
  logic          last_s;
  logic          cnt_clr_s, cnt_en_s;
  logic          din_ready_s, fire_s;

  // Word after the bit on xout has been consumed.
  function automatic logic [W-1:0] shift_next(input logic [W-1:0] v);
    if (MSB_FIRST) begin
      return {v[W-2:0], 1'b0};
    end else begin
      return {1'b0, v[W-1:1]};
    end
  endfunction

  function automatic logic first_bit(input logic [W-1:0] v);
    if (MSB_FIRST) begin
      return v[W-1];
    end else begin
      return v[0];
    end
  endfunction

  seq_bit_cnt #(.W(W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr_s),
    .en   (cnt_en_s),
    .cnt  (cnt_s),
    .last (last_s)
  );

  // Ready is combinational so a new word can slot in on the last-bit edge.
  assign din_ready_s = (state_r == ST_IDLE) ||
                       ((state_r == ST_SHIFT) && last_s && shift_en);
  assign fire_s      = din_valid && din_ready_s;

  // Next-state, next shift register and next registered outputs.
  always_comb begin
    state_s   = state_r;
    sr_s      = sr_r;
    xout_s    = xout_r;
    xv_s      = 1'b0;
    wd_s      = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fire_s) begin
          state_s   = ST_SHIFT;
          sr_s      = din;
          xout_s    = first_bit(din);
          xv_s      = 1'b1;
          cnt_clr_s = 1'b1;
        end else begin
          xout_s = IDLE_LEVEL;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (last_s) begin
            wd_s = 1'b1;
            if (fire_s) begin
              sr_s      = din;
              xout_s    = first_bit(din);
              xv_s      = 1'b1;
              cnt_clr_s = 1'b1;
            end else begin
              state_s   = ST_IDLE;
              sr_s      = '0;
              xout_s    = IDLE_LEVEL;
              cnt_clr_s = 1'b1;
            end
          end else begin
            sr_s     = shift_next(sr_r);
            xout_s   = first_bit(shift_next(sr_r));
            xv_s     = 1'b1;
            cnt_en_s = 1'b1;
          end
        end else begin
          // Stall: hold the bit, but it is no longer a fresh data bit.
          xv_s = 1'b0;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        sr_s      = '0;
        xout_s    = IDLE_LEVEL;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      sr_r    <= '0;
      xout_r  <= IDLE_LEVEL;
      xv_r    <= 1'b0;
      wd_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sr_r    <= sr_s;
      xout_r  <= xout_s;
      xv_r    <= xv_s;
      wd_r    <= wd_s;
      busy_r  <= (state_s == ST_SHIFT);
    end
  end

  assign din_ready  = din_ready_s;
  assign xout       = xout_r;
  assign xout_valid = xv_r;
  assign busy       = busy_r;
  assign word_done  = wd_r;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: one MSB-first and one LSB-first instance,
// W=8, IDLE_LEVEL=0; outputs sampled 1 time unit after each rising edge.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din_a = 8'h00, din_b = 8'h00;
  logic       dv_a = 1'b0, dv_b = 1'b0;
  logic       se_a = 1'b1, se_b = 1'b1;
  logic       rdy_a, rdy_b, x_a, x_b, xv_a, xv_b, busy_a, busy_b, wd_a, wd_b;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  seq_serializer #(.W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
    .shift_en(se_a), .xout(x_a), .xout_valid(xv_a), .busy(busy_a), .word_done(wd_a)
  );

  seq_serializer #(.W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(dv_b), .din_ready(rdy_b),
    .shift_en(se_b), .xout(x_b), .xout_valid(xv_b), .busy(busy_b), .word_done(wd_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    total++; if ({x_a, xv_a, busy_a, wd_a} !== 4'b0000) begin bad++;
      $display("FAIL reset_outs got=%b want=0000", {x_a, xv_a, busy_a, wd_a}); end
    total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", rdy_a); end
    total++; if ({x_b, xv_b, busy_b, wd_b, rdy_b} !== 5'b00001) begin bad++;
      $display("FAIL reset_lsb got=%b want=00001", {x_b, xv_b, busy_b, wd_b, rdy_b}); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] seq;
    logic [4:0] det_sr;
    logic       det;
    seq = 8'b11000000;
    det_sr = 5'b00000;
    det = 1'b0;
    din_a = 8'hC0; dv_a = 1'b1; se_a = 1'b1;
    tick();
    dv_a = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++; if ({x_a, xv_a, wd_a, busy_a} !== {seq[8-c], 1'b1, 1'b0, 1'b1}) begin bad++;
        $display("FAIL single_c%0d got=%b want=%b", c, {x_a, xv_a, wd_a, busy_a}, {seq[8-c], 3'b101}); end
      det_sr = {det_sr[3:0], x_a};
      if (det_sr == 5'b11000) det = 1'b1;
      tick();
    end
    total++; if ({x_a, xv_a, wd_a, busy_a} !== 4'b0010) begin bad++;
      $display("FAIL single_done got=%b want=0010", {x_a, xv_a, wd_a, busy_a}); end
    total++; if (det !== 1'b1) begin bad++; $display("FAIL single_detect got=%b want=1", det); end
    tick();
    total++; if (wd_a !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b want=0", wd_a); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    seq = 16'b11000000_00011000;
    din_a = 8'hC0; dv_a = 1'b1; se_a = 1'b1;
    tick();
    din_a = 8'h18;
    for (int c = 1; c <= 16; c++) begin
      total++; if ({x_a, xv_a} !== {seq[16-c], 1'b1}) begin bad++;
        $display("FAIL b2b_bit_c%0d got=%b want=%b", c, {x_a, xv_a}, {seq[16-c], 1'b1}); end
      total++; if (wd_a !== ((c == 9) ? 1'b1 : 1'b0)) begin bad++;
        $display("FAIL b2b_wd_c%0d got=%b", c, wd_a); end
      if (c == 3) begin
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL b2b_rdy_c3 got=%b want=0", rdy_a); end
      end
      if (c == 8) begin
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL b2b_rdy_c8 got=%b want=1", rdy_a); end
      end
      if (c == 9) dv_a = 1'b0;
      tick();
    end
    total++; if ({wd_a, xv_a, busy_a} !== 3'b100) begin bad++;
      $display("FAIL b2b_done got=%b want=100", {wd_a, xv_a, busy_a}); end
    tick();
  endtask

  task automatic test_stall();
    logic [11:0] ex, ev;
    ex = 12'b101111001010;
    ev = 12'b111000111110;
    din_a = 8'hA5; dv_a = 1'b1; se_a = 1'b1;
    tick();
    dv_a = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      total++; if ({x_a, xv_a, wd_a} !== {ex[12-c], ev[12-c], (c == 12) ? 1'b1 : 1'b0}) begin bad++;
        $display("FAIL stall_c%0d got=%b want=%b", c, {x_a, xv_a, wd_a},
                 {ex[12-c], ev[12-c], (c == 12) ? 1'b1 : 1'b0}); end
      if (c == 3) se_a = 1'b0;
      if (c == 4) begin
        total++; if ({rdy_a, busy_a} !== 2'b01) begin bad++;
          $display("FAIL stall_rdy got=%b want=01", {rdy_a, busy_a}); end
      end
      if (c == 6) se_a = 1'b1;
      tick();
    end
  endtask

  task automatic test_lsb();
    logic [7:0] seq;
    seq = 8'b11000000;
    din_b = 8'h03; dv_b = 1'b1; se_b = 1'b0;
    #1;
    total++; if (rdy_b !== 1'b1) begin bad++; $display("FAIL lsb_idle_rdy got=%b want=1", rdy_b); end
    tick();
    dv_b = 1'b0; se_b = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      total++; if ({x_b, xv_b} !== {seq[8-c], 1'b1}) begin bad++;
        $display("FAIL lsb_c%0d got=%b want=%b", c, {x_b, xv_b}, {seq[8-c], 1'b1}); end
      tick();
    end
    total++; if ({x_b, xv_b, wd_b, busy_b} !== 4'b0010) begin bad++;
      $display("FAIL lsb_done got=%b want=0010", {x_b, xv_b, wd_b, busy_b}); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq;
    seq = 8'h5A;
    din_a = 8'hFF; dv_a = 1'b1; se_a = 1'b1;
    tick();
    dv_a = 1'b0;
    tick(); tick(); tick();
    total++; if ({x_a, xv_a, busy_a} !== 3'b111) begin bad++;
      $display("FAIL rstmid_pre got=%b want=111", {x_a, xv_a, busy_a}); end
    #2 rst = 1'b0;
    #1;
    total++; if ({x_a, xv_a, busy_a, wd_a, rdy_a} !== 5'b00001) begin bad++;
      $display("FAIL rstmid_async got=%b want=00001", {x_a, xv_a, busy_a, wd_a, rdy_a}); end
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if ({xv_a, wd_a, busy_a} !== 3'b000) begin bad++;
        $display("FAIL rstmid_quiet%0d got=%b want=000", c, {xv_a, wd_a, busy_a}); end
    end
    din_a = 8'h5A; dv_a = 1'b1;
    tick();
    dv_a = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++; if ({x_a, xv_a} !== {seq[8-c], 1'b1}) begin bad++;
        $display("FAIL rstmid_next_c%0d got=%b want=%b", c, {x_a, xv_a}, {seq[8-c], 1'b1}); end
      tick();
    end
    total++; if (wd_a !== 1'b1) begin bad++; $display("FAIL rstmid_next_done got=%b want=1", wd_a); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] seq;
    seq = 8'b11000000;
    din_a = 8'hC0; dv_a = 1'b1; se_a = 1'b1;
    tick();
    dv_a = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 4) begin
        din_a = 8'h81; dv_a = 1'b1;
        #1;
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL bp_rdy_cnt3 got=%b want=0", rdy_a); end
      end
      total++; if ({x_a, xv_a, wd_a} !== {seq[8-c], 2'b10}) begin bad++;
        $display("FAIL bp_old_c%0d got=%b want=%b", c, {x_a, xv_a, wd_a}, {seq[8-c], 2'b10}); end
      if (c == 8) begin
        total++; if (rdy_a !== 1'b1) begin bad++; $display("FAIL bp_rdy_last got=%b want=1", rdy_a); end
      end
      tick();
    end
    dv_a = 1'b0;
    total++; if ({x_a, xv_a, wd_a, busy_a} !== 4'b1111) begin bad++;
      $display("FAIL bp_new_c9 got=%b want=1111", {x_a, xv_a, wd_a, busy_a}); end
    tick();
    total++; if ({x_a, xv_a, wd_a} !== 3'b010) begin bad++;
      $display("FAIL bp_new_c10 got=%b want=010", {x_a, xv_a, wd_a}); end
    for (int c = 11; c <= 16; c++) tick();
    total++; if ({x_a, xv_a} !== 2'b11) begin bad++;
      $display("FAIL bp_new_c16 got=%b want=11", {x_a, xv_a}); end
    tick();
    total++; if ({wd_a, busy_a, xv_a} !== 3'b100) begin bad++;
      $display("FAIL bp_new_done got=%b want=100", {wd_a, busy_a, xv_a}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_lsb();
    test_reset_mid();
    test_backpressure();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial stage directly upstream of the 11000 sequence detector.
- Accepts W-bit words over a valid/ready handshake and presents them one bit per clock on xout, which drives the detector's xin.
- Supports back-to-back words with no idle bubble, a stall input, and MSB- or LSB-first ordering.

Parameters:
- W, 8: word width in bits; legal values are 2 to 32.
- MSB_FIRST, 1: 1 sends din[W-1] first; 0 sends din[0] first.
- IDLE_LEVEL, 0: value driven on xout while no word is being shifted.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- din  in  W  parallel word to serialize.
- din_valid  in  1  din holds a word to transfer.
- din_ready  out  1  block will accept din at the next rising edge.
- shift_en  in  1  1 advances one bit per cycle; 0 stalls.
- xout  out  1  serial bit to the detector's xin; registered.
- xout_valid  out  1  xout carries a live data bit this cycle; registered.
- busy  out  1  a word is in flight; registered.
- word_done  out  1  one-cycle pulse after the last bit of a word is consumed; registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - xout=IDLE_LEVEL, xout_valid=0, busy=0, word_done=0.
  - A reset mid-word aborts that word; its remaining bits are never emitted.
- State machine (state encoding in the package):
  - IDLE: no word loaded.
  - SHIFT: a word is loaded; the counter cnt (width clog2(W)) indexes the bit currently on xout.
- Handshake:
  - A transfer occurs at a rising edge where din_valid=1 and din_ready=1.
  - din_ready is combinational: (state==IDLE) or (state==SHIFT and cnt==W-1 and shift_en==1).
  - While din_ready=0, din is ignored; the source must hold din and din_valid until the transfer.
- Load:
  - A transfer at edge k loads din into the shift register and sets cnt=0.
  - The first bit is on xout with xout_valid=1 from edge k onward, so latency is one cycle.
- Shift:
  - In SHIFT, each edge with shift_en=1 advances to the next bit and cnt increments.
  - Bit order follows MSB_FIRST.
- Stall:
  - shift_en=0 holds xout and cnt.
  - xout_valid drops to 0 from the next edge and returns to 1 at the first edge with shift_en=1.
  - The downstream detector samples every clock, so gating repeated bits during a stall is the integrator's responsibility.
- Last bit (cnt==W-1) with shift_en=1:
  - If a transfer occurs on that edge, the new word's first bit follows with no gap and state stays SHIFT.
  - Otherwise state goes to IDLE: xout=IDLE_LEVEL, xout_valid=0, busy=0.
- word_done: pulses high for exactly one cycle after each edge that consumes a last bit, including back-to-back words.
- busy equals (state==SHIFT).
- A transfer presented in the same cycle as shift_en=0 is accepted only if din_ready=1, which in IDLE is independent of shift_en.
- IDLE_LEVEL=0 appends zeros after a word; the detector can flag 11000 across the word/idle boundary. This is intended and must not be filtered here.

Decomposition:
- Package seq_pkg holds:
  - state constants ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - default word width SEQ_W=8;
  - clog2 helper function.
- Sub-module seq_bit_cnt: modulo-W bit counter with enable, clear and last-flag output. The serializer instantiates it.
- No other sub-modules.

Test Plan:
1. W=8, MSB_FIRST=1, shift_en=1, din=8'hC0 accepted at edge 1 -> xout=1,1,0,0,0,0,0,0 over cycles 1-8 with xout_valid=1; word_done pulses in cycle 9; xout=0 and busy=0 in cycle 9; detector driven by xout asserts out.
2. Back-to-back: 8'hC0 then 8'h18, din_valid held high -> second word's first bit in cycle 9 with no gap; 16 consecutive valid bits; word_done pulses in cycles 9 and 17.
3. Stall: 8'hA5, shift_en=0 for cycles 3-5 -> xout holds bit 2 (=1), xout_valid=0 in cycles 4-6; full sequence 1,0,1,0,0,1,0,1 still delivered in order.
4. MSB_FIRST=0, din=8'h03 -> xout=1,1,0,0,0,0,0,0.
5. Reset mid-word: rst=0 asserted asynchronously in cycle 4 of 8'hFF -> xout=IDLE_LEVEL, xout_valid=0, busy=0 and din_ready=1 immediately; no word_done; the next word starts cleanly after rst=1.
6. Backpressure: din_valid=1 with new data at cnt=3 -> din_ready=0 and the current word is unaffected; the new word is accepted only at the cnt==7 edge.
